// File: rtl/relu_backward_mask.sv
// ReLU backward mask: records one derivative bit per forward pre-activation in a small FIFO
// and gates each backprop gradient with the oldest bit. Option: RELU_BWD_SAT_MASK_EN.
module relu_backward_mask #(
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 1,
    parameter int DEPTH          = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       fwd_valid,
    output logic                       fwd_ready,
    input  logic [2*dataWidth-1:0]     fwd_x,
    input  logic                       grad_valid,
    output logic                       grad_ready,
    input  logic [dataWidth-1:0]       grad_in,
    output logic                       gout_valid,
    input  logic                       gout_ready,
    output logic [dataWidth-1:0]       grad_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int XW = 2 * dataWidth;
    localparam int SW = weightIntWidth + 8;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] mask_mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             pos;
    logic             mask_bit;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // ready depends only on registered state (and gout_ready), never on the same-side valid.
    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign fwd_ready  = !full;
    assign grad_ready = !empty && (!gout_valid || gout_ready);
    assign push       = fwd_valid && fwd_ready;
    assign pop        = grad_valid && grad_ready;

    assign pos = ($signed(fwd_x) >= 0);

`ifdef RELU_BWD_SAT_MASK_EN
    // Saturated forward outputs are flat, so their derivative is zero.
    logic sat;
    assign sat      = |fwd_x[XW-1 -: SW];
    assign mask_bit = pos && !sat;
`else
    assign mask_bit = pos;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_mem   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            gout_valid <= 1'b0;
            grad_out   <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            gout_valid <= 1'b0;
            grad_out   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                mask_mem[wr_ptr] <= mask_bit;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            // A new pop refills the output stage; otherwise a completed handshake empties it.
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                grad_out   <= mask_mem[rd_ptr] ? grad_in : '0;
                gout_valid <= 1'b1;
            end else if (gout_ready) begin
                gout_valid <= 1'b0;
            end
            if (fwd_valid && full) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_backward_mask.sv
// Self-checking bench for relu_backward_mask: mask model queue plus expected-output scoreboard.
module tb_relu_backward_mask;

    localparam int DW    = 16;
    localparam int WIW   = 1;
    localparam int DEPTH = 8;
    localparam int XW    = 2 * DW;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          fwd_valid;
    logic          fwd_ready;
    logic [XW-1:0] fwd_x;
    logic          grad_valid;
    logic          grad_ready;
    logic [DW-1:0] grad_in;
    logic          gout_valid;
    logic          gout_ready;
    logic [DW-1:0] grad_out;
    logic [3:0]    count;
    logic          overflow;

    logic [DW-1:0] exp_q[$];
    logic          mask_q[$];
    logic          model_ovf;
    int            n_checks;
    int            n_errors;

    relu_backward_mask #(.dataWidth(DW), .weightIntWidth(WIW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .fwd_valid  (fwd_valid),
        .fwd_ready  (fwd_ready),
        .fwd_x      (fwd_x),
        .grad_valid (grad_valid),
        .grad_ready (grad_ready),
        .grad_in    (grad_in),
        .gout_valid (gout_valid),
        .gout_ready (gout_ready),
        .grad_out   (grad_out),
        .count      (count),
        .overflow   (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_mask(input logic [XW-1:0] x);
        logic p;
        logic s;
        p = !x[XW-1];
        s = |x[XW-1 -: WIW + 8];
`ifdef RELU_BWD_SAT_MASK_EN
        return p && !s;
`else
        if (s) return p;
        return p;
`endif
    endfunction

    function automatic void model_flush();
        exp_q.delete();
        mask_q.delete();
        model_ovf = 1'b0;
    endfunction

    // driver tasks: start and end at 1 time unit after a rising edge
    task automatic push_fwd(input logic [XW-1:0] x);
        fwd_valid = 1'b1;
        fwd_x     = x;
        @(negedge clk);
        check("fwd_ready", 32'(fwd_ready), 32'(mask_q.size() < DEPTH));
        @(posedge clk);
        #1;
        fwd_valid = 1'b0;
        if (mask_q.size() < DEPTH) mask_q.push_back(model_mask(x));
        else model_ovf = 1'b1;
    endtask

    task automatic send_grad(input logic [DW-1:0] g);
        logic hs;
        hs         = 1'b0;
        grad_valid = 1'b1;
        grad_in    = g;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            if (grad_ready) begin
                hs = 1'b1;
                if (mask_q.size() == 0) check("grad_pop_empty", 32'd1, 32'd0);
                else exp_q.push_back(mask_q.pop_front() ? g : '0);
            end
            @(posedge clk);
            #1;
        end
        if (!hs) check("grad_timeout", 32'd0, 32'd1);
        grad_valid = 1'b0;
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_gout_valid"}, 32'(gout_valid), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_fwd_ready"}, 32'(fwd_ready), 32'd1);
        check({tag, "_grad_ready"}, 32'(grad_ready), 32'd0);
    endtask

    // scoreboard: compare each accepted output against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && gout_valid && gout_ready) begin
            if (exp_q.size() == 0) check("unexpected_gout", 32'd1, 32'd0);
            else check("gout_data", 32'(grad_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [XW-1:0] rx;
        logic [DW-1:0] m;
        n_checks   = 0;
        n_errors   = 0;
        model_ovf  = 1'b0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        fwd_valid  = 1'b0;
        fwd_x      = '0;
        grad_valid = 1'b0;
        grad_in    = '0;
        gout_ready = 1'b1;
        #2;
        check_idle_state("reset");
        check("reset_grad_out", 32'(grad_out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: positive pre-activation passes gradient, latency one cycle
        push_fwd(32'h0000_0100);
        check("t1_count", 32'(count), 32'd1);
        check("t1_gout_before", 32'(gout_valid), 32'd0);
        send_grad(16'h0180);
        check("t1_gout_latency", 32'(gout_valid), 32'd1);
        check("t1_grad_out", 32'(grad_out), 32'h0180);
        @(posedge clk);
        #1;

        // 2: negative blocks, zero passes
        push_fwd(32'hFFFF_FF00);
        push_fwd(32'h0000_0000);
        send_grad(16'h0200);
        send_grad(16'h0345);
        @(posedge clk);
        #1;

        // 3: saturated region (masked only when the option is enabled)
        push_fwd(32'h0080_0000);
        send_grad(16'h0100);
        @(posedge clk);
        #1;
        check("t3_empty_count", 32'(count), 32'd0);

        // empty FIFO with gradient pending: no pop, no output
        grad_valid = 1'b1;
        grad_in    = 16'h7777;
        repeat (2) begin
            @(negedge clk);
            check("empty_grad_ready", 32'(grad_ready), 32'd0);
            check("empty_gout_valid", 32'(gout_valid), 32'd0);
        end
        @(posedge clk);
        #1 grad_valid = 1'b0;

        // 4: fill, overflow on ninth push, pop frees a slot
        for (int i = 0; i < DEPTH; i++) push_fwd(32'(i * 16'h0101));
        check("t4_count_full", 32'(count), 32'd8);
        check("t4_fwd_ready_full", 32'(fwd_ready), 32'd0);
        push_fwd(32'h0000_0042);
        check("t4_overflow", 32'(overflow), 32'(model_ovf));
        check("t4_count_stays", 32'(count), 32'd8);
        send_grad(16'h0011);
        check("t4_fwd_ready_after_pop", 32'(fwd_ready), 32'd1);
        for (int i = 0; i < DEPTH - 1; i++) send_grad(DW'(16'h0020 + i));
        @(posedge clk);
        #1;
        check("t4_overflow_sticky", 32'(overflow), 32'd1);

        // simultaneous push and pop keep the count
        push_fwd(32'h0000_0300);
        push_fwd(32'hFFFF_8000);
        fwd_valid  = 1'b1;
        fwd_x      = 32'h0000_0500;
        grad_valid = 1'b1;
        grad_in    = 16'h0ABC;
        @(negedge clk);
        check("simul_fwd_ready", 32'(fwd_ready), 32'd1);
        check("simul_grad_ready", 32'(grad_ready), 32'd1);
        exp_q.push_back(mask_q.pop_front() ? 16'h0ABC : 16'h0000);
        mask_q.push_back(model_mask(32'h0000_0500));
        @(posedge clk);
        #1;
        fwd_valid  = 1'b0;
        grad_valid = 1'b0;
        check("simul_count", 32'(count), 32'd2);
        send_grad(16'h0D00);
        send_grad(16'h0E00);

        // 5: output stall holds data and blocks pops, then drains back to back
        push_fwd(32'h0000_0100);
        push_fwd(32'hFFFF_0000);
        push_fwd(32'h0000_0200);
        gout_ready = 1'b0;
        grad_valid = 1'b1;
        grad_in    = 16'h0111;
        @(negedge clk);
        check("t5_first_ready", 32'(grad_ready), 32'd1);
        exp_q.push_back(mask_q.pop_front() ? 16'h0111 : 16'h0000);
        @(posedge clk);
        #1 grad_in = 16'h0222;
        repeat (3) begin
            @(negedge clk);
            check("t5_hold_valid", 32'(gout_valid), 32'd1);
            check("t5_hold_data", 32'(grad_out), 32'h0111);
            check("t5_hold_ready", 32'(grad_ready), 32'd0);
            check("t5_hold_count", 32'(count), 32'd2);
        end
        @(posedge clk);
        #1 gout_ready = 1'b1;
        @(negedge clk);
        check("t5_ready2", 32'(grad_ready), 32'd1);
        exp_q.push_back(mask_q.pop_front() ? 16'h0222 : 16'h0000);
        @(posedge clk);
        #1 grad_in = 16'h0333;
        @(negedge clk);
        check("t5_ready3", 32'(grad_ready), 32'd1);
        check("t5_consec_valid2", 32'(gout_valid), 32'd1);
        exp_q.push_back(mask_q.pop_front() ? 16'h0333 : 16'h0000);
        @(posedge clk);
        #1 grad_valid = 1'b0;
        @(negedge clk);
        check("t5_consec_valid3", 32'(gout_valid), 32'd1);
        @(negedge clk);
        check("t5_drained", 32'(gout_valid), 32'd0);
        @(posedge clk);
        #1;

        // random traffic
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       rx = 32'($urandom_range(0, 32'h007F_FFFF));
                1:       rx = 32'hFF00_0000 | 32'($urandom_range(0, 32'h00FF_FFFF));
                default: rx = 32'($urandom());
            endcase
            push_fwd(rx);
            if ($urandom_range(0, 1) == 1 || mask_q.size() >= 4) begin
                m = DW'($urandom_range(0, 16'hFFFF));
                send_grad(m);
            end
        end
        while (mask_q.size() > 0) send_grad(DW'($urandom_range(0, 16'hFFFF)));
        repeat (2) @(posedge clk);
        #1;

        // 6a: asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) push_fwd(32'h0000_0400);
        gout_ready = 1'b0;
        send_grad(16'h0444);
        check("t6_pre_count", 32'(count), 32'd5);
        check("t6_pre_gout", 32'(gout_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_state("t6_async");
        check("t6_async_grad_out", 32'(grad_out), 32'd0);
        model_flush();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 6b: synchronous clear also drops overflow
        for (int i = 0; i < DEPTH + 1; i++) push_fwd(32'h0000_0500);
        send_grad(16'h0555);
        check("t6b_pre_overflow", 32'(overflow), 32'd1);
        check("t6b_pre_gout", 32'(gout_valid), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        check("t6b_not_yet", 32'(count), 32'd7);
        @(posedge clk);
        #1 clear = 1'b0;
        model_flush();
        check_idle_state("t6b_clear");
        gout_ready = 1'b1;

        // after clear the FIFO works normally again
        push_fwd(32'h0000_0600);
        send_grad(16'h0666);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
